// File: rtl/mcp3008_reader.sv
// mcp3008_reader: SPI mode-0 scanner for an MCP3008, single-ended, 8-entry bank.
// Optional macro MCP3008_NULL_CHECK_EN drops frames whose null bit reads 1.

module mcp3008_reader #(
    parameter int         CLK_DIV = 4,
    parameter int         CSN_GAP = 8,
    parameter logic [7:0] CH_MASK = 8'hFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    output logic            sclk,
    output logic            csn,
    output logic            mosi,
    input  logic            miso,
    output logic [7:0][9:0] data,
    output logic [7:0]      valid,
    output logic            upd,
    output logic [2:0]      upd_ch,
`ifdef MCP3008_NULL_CHECK_EN
    output logic            null_err,
`endif
    output logic            busy
);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, GAP} state_t;

    localparam int CW = 16;

    function automatic logic [2:0] next_set(input logic [2:0] c);
        logic [2:0] r;
        logic [2:0] t;
        r = c;
        for (int k = 8; k >= 1; k--) begin
            t = c + 3'(k);
            if (CH_MASK[t]) r = t;
        end
        return r;
    endfunction

    localparam logic [2:0] FIRST_CH = next_set(3'd7);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [4:0]    bidx;
    logic [2:0]    ch;
    logic [2:0]    addr;
    logic [9:0]    sr;
    logic          last;
    logic          enter;
    logic          wr_ok;
    logic          sclk_n;
    logic          csn_n;
    logic          mosi_n;
    logic          busy_n;

`ifdef MCP3008_NULL_CHECK_EN
    logic null_bad;
    assign wr_ok = !null_bad;
`else
    assign wr_ok = 1'b1;
`endif

    assign last  = (state == GAP) ? (cnt == CW'(CSN_GAP - 1))
                                  : (cnt == CW'(CLK_DIV - 1));
    assign enter = (state_n != state);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: phase sequencing driven by the per-phase counter.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en && CH_MASK != 8'd0) state_n = SETUP;
            SETUP:   if (last) state_n = HIGH;
            HIGH:    if (last) state_n = (bidx == 5'd16) ? TAIL : LOW;
            LOW:     if (last) state_n = HIGH;
            TAIL:    if (last) state_n = GAP;
            GAP:     if (last) state_n = en ? SETUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Pin values for the next cycle; mosi moves only as sclk falls.
    always_comb begin
        sclk_n = (state_n == HIGH);
        csn_n  = (state_n == IDLE) || (state_n == GAP);
        busy_n = (state_n != IDLE);
        mosi_n = mosi;
        if (state_n == SETUP) begin
            mosi_n = 1'b1;
        end else if (state == HIGH && state_n == LOW) begin
            unique case (bidx)
                5'd0:    mosi_n = 1'b1;
                5'd1:    mosi_n = addr[2];
                5'd2:    mosi_n = addr[1];
                5'd3:    mosi_n = addr[0];
                default: mosi_n = 1'b0;
            endcase
        end else if (state_n == TAIL || csn_n) begin
            mosi_n = 1'b0;
        end
    end

    // Registered pins, counters, shift register and result bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            bidx   <= '0;
            ch     <= FIRST_CH;
            addr   <= '0;
            sr     <= '0;
            sclk   <= 1'b0;
            csn    <= 1'b1;
            mosi   <= 1'b0;
            busy   <= 1'b0;
            data   <= '0;
            valid  <= '0;
            upd    <= 1'b0;
            upd_ch <= '0;
`ifdef MCP3008_NULL_CHECK_EN
            null_bad <= 1'b0;
            null_err <= 1'b0;
`endif
        end else begin
            sclk <= sclk_n;
            csn  <= csn_n;
            mosi <= mosi_n;
            busy <= busy_n;
            upd  <= 1'b0;
`ifdef MCP3008_NULL_CHECK_EN
            null_err <= 1'b0;
`endif
            cnt <= (enter || state == IDLE) ? '0 : cnt + CW'(1);
            if (state_n == SETUP && enter) begin
                addr <= ch;
`ifdef MCP3008_NULL_CHECK_EN
                null_bad <= 1'b0;
`endif
            end
            if (state == SETUP && state_n == HIGH) bidx <= '0;
            if (state == HIGH && state_n == LOW) bidx <= bidx + 5'd1;
            if (state == LOW && state_n == HIGH) begin
                if (bidx >= 5'd7) sr <= {sr[8:0], miso};
`ifdef MCP3008_NULL_CHECK_EN
                if (bidx == 5'd6) null_bad <= miso;
`endif
            end
            if (state == TAIL && state_n == GAP) begin
                ch <= next_set(ch);
                if (wr_ok) begin
                    data[ch]  <= sr;
                    valid[ch] <= 1'b1;
                    upd       <= 1'b1;
                    upd_ch    <= ch;
                end
`ifdef MCP3008_NULL_CHECK_EN
                else begin
                    null_err <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_reader.sv
// tb_mcp3008_reader: three scanner instances against a behavioural MCP3008.
// Scoreboard queue per instance, fed at frame end, drained on upd.

module tb_mcp3008_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] en  = 3'b000;
    bit         inj_req = 1'b0;
    int         cyc = 0;
    int         mchecks = 0;
    int         mfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam logic [7:0] MASK = (gi == 0) ? 8'hFF :
                                      (gi == 1) ? 8'hA4 : 8'h00;
        localparam int DIV  = (gi == 1) ? 1 : 2;
        localparam int GAPC = (gi == 1) ? 3 : 4;

        logic            sclk, csn, mosi, upd, busy;
        logic            miso = 1'b0;
        logic [7:0][9:0] data;
        logic [7:0]      valid;
        logic [2:0]      upd_ch;
        logic            null_err;

        logic [12:0]     q[$];
        logic [12:0]     e;
        int              nchecks = 0, nfail = 0, upd_cnt = 0, sedges = 0;
        int              k = 0, null_seen = 0, null_pend = 0;
        logic [2:0]      exp_ch = 3'd0, fch = 3'd0;
        logic [4:0]      cmd = 5'd0;
        logic [9:0]      val = 10'd0;
        logic [7:0][9:0] sh_data = '0;
        logic [7:0]      sh_valid = '0;
        logic            sclk_q = 1'b0, csn_q = 1'b1;
        bit              inj_now = 1'b0, inj_used = 1'b0;

`ifndef MCP3008_NULL_CHECK_EN
        assign null_err = 1'b0;
`endif

        mcp3008_reader #(.CLK_DIV(DIV), .CSN_GAP(GAPC), .CH_MASK(MASK)) u_dut (
            .clk(clk), .rst(rst), .en(en[gi]),
            .sclk(sclk), .csn(csn), .mosi(mosi), .miso(miso),
            .data(data), .valid(valid), .upd(upd), .upd_ch(upd_ch),
`ifdef MCP3008_NULL_CHECK_EN
            .null_err(null_err),
`endif
            .busy(busy)
        );

        // Next enabled channel after c, ascending with wrap.
        function automatic logic [2:0] nxt(input logic [2:0] c);
            for (int s = 1; s <= 8; s++)
                if (MASK[3'(c + 3'(s))]) return 3'(c + 3'(s));
            return c;
        endfunction

        task automatic chk(input string nm, input logic [79:0] act,
                           input logic [79:0] exp);
            nchecks++;
            if (act !== exp) begin
                nfail++;
                $display("FAIL %s inst%0d t=%0d got=%h want=%h",
                         nm, gi, cyc, act, exp);
            end
        endtask

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                exp_ch   = nxt(3'd7);
                sh_data  = '0;
                sh_valid = '0;
                k        = 0;
                miso     = 1'b0;
                inj_now  = 1'b0;
            end else begin
                // ADC model
                if (!csn && csn_q) begin
                    k   = 0;
                    cmd = '0;
                    val = 10'($urandom_range(0, 1023));
                    fch = exp_ch;
                    if (gi == 0 && inj_req && !inj_used && exp_ch == 3'd4) begin
                        inj_now  = 1'b1;
                        inj_used = 1'b1;
                    end
                end
                if (sclk && !sclk_q) begin
                    sedges++;
                    if (k < 5) cmd[4-k] = mosi;
                    k++;
                    if (k == 5) begin
                        chk("start_sgl", 80'(cmd[4:3]), 80'(2'b11));
                        chk("addr", 80'(cmd[2:0]), 80'(fch));
                    end
                end
                if (!sclk && sclk_q && !csn) begin
                    if (k == 6)                miso = inj_now;
                    else if (k >= 7 && k <= 16) miso = val[16-k];
                    else                       miso = 1'b0;
                end
                if (csn && !csn_q) begin
                    chk("edges", 80'(k), 80'(17));
                    if (inj_now) null_pend++;
                    else q.push_back({fch, val});
                    inj_now = 1'b0;
                    exp_ch  = nxt(exp_ch);
                end
                // monitor
                if (upd) begin
                    upd_cnt++;
                    if (q.size() == 0) begin
                        nchecks++;
                        nfail++;
                        $display("FAIL unexpected_upd inst%0d t=%0d got=upd_ch %0d want=none",
                                 gi, cyc, upd_ch);
                    end else begin
                        e = q.pop_front();
                        chk("upd_ch", 80'(upd_ch), 80'(e[12:10]));
                        sh_data[e[12:10]]  = e[9:0];
                        sh_valid[e[12:10]] = 1'b1;
                    end
                    chk("data", data, sh_data);
                    chk("valid", 80'(valid), 80'(sh_valid));
                end
                if (q.size() != 0) begin
                    nchecks++;
                    nfail++;
                    $display("FAIL missing_upd inst%0d t=%0d got=0 want=1", gi, cyc);
                    q.delete();
                end
                if (null_err) begin
                    null_seen++;
                    chk("null_expected", 80'(null_pend > 0), 80'(1));
                    chk("null_no_upd", 80'(upd), 80'(0));
                    if (null_pend > 0) null_pend--;
                end
            end
            sclk_q = sclk;
            csn_q  = csn;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic mchk(input string nm, input logic [79:0] act,
                        input logic [79:0] exp);
        mchecks++;
        if (act !== exp) begin
            mfail++;
            $display("FAIL %s t=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic csn_of(input int w);
        return (w == 0) ? g[0].csn : g[1].csn;
    endfunction

    task automatic period(input int w, input int exp, input string nm);
        int  t0;
        logic prev, cur;
        t0   = -1;
        prev = csn_of(w);
        for (int n = 0; n < 2000; n++) begin
            tick();
            cur = csn_of(w);
            if (!cur && prev) begin
                if (t0 < 0) begin
                    t0 = cyc;
                end else begin
                    mchk(nm, 80'(cyc - t0), 80'(exp));
                    return;
                end
            end
            prev = cur;
        end
        mchk({nm, "_timeout"}, 80'(0), 80'(exp));
    endtask

    initial begin
        int u, s;
        logic [9:0] d4;
        rst = 1'b1;
        en  = 3'b000;
        repeat (4) tick();
        mchk("rst_csn", 80'(g[0].csn), 80'(1));
        mchk("rst_sclk", 80'(g[0].sclk), 80'(0));
        mchk("rst_mosi", 80'(g[0].mosi), 80'(0));
        mchk("rst_busy", 80'(g[0].busy), 80'(0));
        mchk("rst_upd", 80'({g[0].upd, g[0].upd_ch}), 80'(0));
        mchk("rst_valid", 80'(g[0].valid), 80'(0));
        mchk("rst_data", g[0].data, 80'(0));
        rst = 1'b0;
        tick();
        mchk("idle_csn", 80'({g[0].csn, g[0].busy}), 80'(2'b10));
        en = 3'b111;

        period(0, 74, "period0");
        period(1, 38, "period1");

        for (int n = 0; n < 1500 && g[0].upd_cnt < 9; n++) tick();
        mchk("upd_cnt0", 80'(g[0].upd_cnt >= 9), 80'(1));
        mchk("valid0_all", 80'(g[0].valid), 80'(8'hFF));
        mchk("upd_cnt1", 80'(g[1].upd_cnt >= 4), 80'(1));
        mchk("valid1_mask", 80'(g[1].valid), 80'(8'hA4));
        mchk("mask0_pins", 80'({g[2].csn, g[2].sclk, g[2].busy}), 80'(3'b100));
        mchk("mask0_quiet", 80'(g[2].upd_cnt + g[2].sedges), 80'(0));

        // reset inside the ch1 frame just after sclk edge 9
        for (int n = 0; n < 1500; n++) begin
            if (g[0].fch == 3'd1 && g[0].k == 10 && !g[0].csn) break;
            tick();
        end
        mchk("found_ch1_e9", 80'(g[0].fch == 3'd1 && g[0].k == 10), 80'(1));
        rst = 1'b1;
        tick();
        mchk("abort_pins", 80'({g[0].csn, g[0].sclk}), 80'(2'b10));
        mchk("abort_data1", 80'(g[0].data[1]), 80'(0));
        tick();
        rst = 1'b0;
        tick();
        mchk("abort_valid", 80'(g[0].valid), 80'(0));
        for (int n = 0; n < 300 && !g[0].upd; n++) tick();
        mchk("restart_ch", 80'({g[0].upd, g[0].upd_ch}), 80'({1'b1, 3'd0}));

        // drop en mid-frame right after edge 3
        for (int n = 0; n < 300; n++) begin
            if (g[0].k == 4 && !g[0].csn) break;
            tick();
        end
        en[0] = 1'b0;
        u = g[0].upd_cnt;
        for (int n = 0; n < 300 && g[0].upd_cnt == u; n++) tick();
        mchk("drop_upd", 80'(g[0].upd_cnt - u), 80'(1));
        s = g[0].sedges;
        repeat (200) tick();
        mchk("drop_edges", 80'(g[0].sedges - s), 80'(0));
        mchk("drop_pins", 80'({g[0].csn, g[0].busy}), 80'(2'b10));
        mchk("drop_no_upd", 80'(g[0].upd_cnt - u), 80'(1));

`ifdef MCP3008_NULL_CHECK_EN
        d4      = g[0].data[4];
        inj_req = 1'b1;
        en[0]   = 1'b1;
        for (int n = 0; n < 1500 && g[0].null_seen == 0; n++) tick();
        u = g[0].upd_cnt;
        for (int n = 0; n < 400 && g[0].upd_cnt < u + 2; n++) tick();
        mchk("null_once", 80'(g[0].null_seen), 80'(1));
        mchk("null_data4", 80'(g[0].data[4]), 80'(d4));
`else
        d4 = '0;
        mchk("null_off", 80'(g[0].null_seen), 80'(d4));
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 mchecks + g[0].nchecks + g[1].nchecks + g[2].nchecks,
                 mfail + g[0].nfail + g[1].nfail + g[2].nfail);
        $finish;
    end

endmodule
